// File: rtl/sokoban_pkg.sv
// Shared Sokoban definitions: board geometry, sprite ids, render FSM encoding
// and the board-RAM address helper.
package sokoban_pkg;

    localparam int unsigned TILE_PX       = 8;
    localparam int unsigned COLS          = 20;
    localparam int unsigned ROWS          = 15;
    localparam int unsigned SPRITE_PERIOD = 66;

    localparam int unsigned COL_W  = 5;
    localparam int unsigned ROW_W  = 4;
    localparam int unsigned ADDR_W = 9;
    localparam int unsigned X_W    = 8;
    localparam int unsigned Y_W    = 7;
    localparam int unsigned ID_W   = 3;

    typedef logic [COL_W-1:0]  col_t;
    typedef logic [ROW_W-1:0]  row_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [ID_W-1:0]   sprite_t;

    localparam sprite_t FLOOR          = 3'd0;
    localparam sprite_t WALL           = 3'd1;
    localparam sprite_t BOX            = 3'd2;
    localparam sprite_t GOAL           = 3'd3;
    localparam sprite_t BOX_ON_GOAL    = 3'd4;
    localparam sprite_t PLAYER         = 3'd5;
    localparam sprite_t PLAYER_ON_GOAL = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_ISSUE,
        S_HOLD
    } state_e;

    typedef enum logic {
        MODE_FULL,
        MODE_SINGLE
    } mode_e;

    // Row-major board RAM address; the board is never wider than 2^COL_W tiles.
    function automatic addr_t tile_addr(input col_t col, input row_t row,
                                        input int unsigned cols);
        return addr_t'(row) * addr_t'(cols) + addr_t'(col);
    endfunction

endpackage

// File: rtl/board_render_draw_pacer.sv
// Loadable down-counter that spaces draw requests; o_expire_c flags the
// cycle whose decrement brings the count to zero.
module draw_pacer #(
    parameter int unsigned W = 7
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_expire_c
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    // A load value of zero expires on the first hold cycle rather than stalling.
    assign o_expire_c = (r_cnt <= W'(1));

endmodule

// File: rtl/board_render.sv
// Walks the board map and issues one paced draw request per tile to
// sprite_draw, either for the whole board or for a single tile.
module board_render #(
    parameter int unsigned COLS          = sokoban_pkg::COLS,
    parameter int unsigned ROWS          = sokoban_pkg::ROWS,
    parameter int unsigned SPRITE_PERIOD = sokoban_pkg::SPRITE_PERIOD
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       tile_req,
    input  logic [4:0] tile_x,
    input  logic [3:0] tile_y,
    output logic [8:0] map_addr,
    input  logic [2:0] map_data,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] sprite_id,
    output logic       begin_draw,
    output logic       busy,
    output logic       done
);

    import sokoban_pkg::*;

    localparam int unsigned CNT_W = (SPRITE_PERIOD > 2) ? $clog2(SPRITE_PERIOD) : 1;
    typedef logic [CNT_W-1:0] cnt_t;

    state_e    r_state, w_state_nxt;
    mode_e     r_mode,  w_mode_nxt;
    col_t      r_col,   w_col_nxt;
    row_t      r_row,   w_row_nxt;
    addr_t     r_addr,  w_addr_nxt;
    logic [7:0] r_x,    w_x_nxt;
    logic [6:0] r_y,    w_y_nxt;
    sprite_t   r_id,    w_id_nxt;
    logic      r_begin, w_begin_nxt;
    logic      r_busy,  w_busy_nxt;
    logic      r_done,  w_done_nxt;

    logic      w_load;
    logic      w_dec;
    logic      w_expire;
    logic      w_tile_ok;
    logic      w_last_tile;
    col_t      w_adv_col;
    row_t      w_adv_row;

    draw_pacer #(
        .W (CNT_W)
    ) u_pacer (
        .clk        (clk),
        .resetn     (resetn),
        .i_load     (w_load),
        .i_load_val (cnt_t'(SPRITE_PERIOD - 1)),
        .i_dec      (w_dec),
        .o_expire_c (w_expire)
    );

    assign w_tile_ok   = (32'(tile_x) < COLS) && (32'(tile_y) < ROWS);
    assign w_last_tile = (32'(r_col) == COLS - 1) && (32'(r_row) == ROWS - 1);

    // Raster-order successor of the current tile.
    always_comb begin
        w_adv_col = r_col + col_t'(1);
        w_adv_row = r_row;
        if (32'(r_col) == COLS - 1) begin
            w_adv_col = '0;
            w_adv_row = r_row + row_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_mode  <= MODE_FULL;
            r_col   <= '0;
            r_row   <= '0;
            r_addr  <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_id    <= '0;
            r_begin <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= w_mode_nxt;
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
            r_addr  <= w_addr_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_id    <= w_id_nxt;
            r_begin <= w_begin_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // The address is registered on entry to FETCH so the RAM sees it for the
    // whole FETCH cycle and its data lands in LATCH.
    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_addr_nxt  = r_addr;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_id_nxt    = r_id;
        w_begin_nxt = 1'b0;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_load      = 1'b0;
        w_dec       = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_mode_nxt  = MODE_FULL;
                    w_col_nxt   = '0;
                    w_row_nxt   = '0;
                    w_addr_nxt  = '0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_FETCH;
                end else if (tile_req && w_tile_ok) begin
                    w_mode_nxt  = MODE_SINGLE;
                    w_col_nxt   = tile_x;
                    w_row_nxt   = tile_y;
                    w_addr_nxt  = tile_addr(tile_x, tile_y, COLS);
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                w_state_nxt = S_LATCH;
            end
            S_LATCH: begin
                w_id_nxt    = map_data;
                w_x_nxt     = {r_col, 3'b000};
                w_y_nxt     = {r_row, 3'b000};
                w_begin_nxt = 1'b1;
                w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                w_load      = 1'b1;
                w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                w_dec = 1'b1;
                if (w_expire) begin
                    if ((r_mode == MODE_SINGLE) || w_last_tile) begin
                        w_done_nxt  = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_col_nxt   = w_adv_col;
                        w_row_nxt   = w_adv_row;
                        w_addr_nxt  = tile_addr(w_adv_col, w_adv_row, COLS);
                        w_state_nxt = S_FETCH;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign map_addr   = r_addr;
    assign x_out      = r_x;
    assign y_out      = r_y;
    assign sprite_id  = r_id;
    assign begin_draw = r_begin;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_board_render.sv
// Directed bench for board_render: single tile, out-of-range, collision with
// full redraw, and reset in the middle of a redraw.
module tb_board_render;

    logic       clk;
    logic       resetn;
    logic       start;
    logic       tile_req;
    logic [4:0] tile_x;
    logic [3:0] tile_y;
    logic [8:0] map_addr;
    logic [2:0] map_data;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] sprite_id;
    logic       begin_draw;
    logic       busy;
    logic       done;

    board_render dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .tile_req   (tile_req),
        .tile_x     (tile_x),
        .tile_y     (tile_y),
        .map_addr   (map_addr),
        .map_data   (map_data),
        .x_out      (x_out),
        .y_out      (y_out),
        .sprite_id  (sprite_id),
        .begin_draw (begin_draw),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Board RAM with one cycle of read latency.
    logic [2:0] ram [0:511];
    always @(posedge clk) map_data <= ram[map_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every draw pulse with what it carried.
    int p_cyc[$];
    int p_addr[$];
    int p_x[$];
    int p_y[$];
    int p_id[$];
    int done_cnt = 0;
    always @(negedge clk) begin
        if (begin_draw === 1'b1) begin
            p_cyc.push_back(cyc);
            p_addr.push_back(int'(map_addr));
            p_x.push_back(int'(x_out));
            p_y.push_back(int'(y_out));
            p_id.push_back(int'(sprite_id));
        end
        if (done === 1'b1) done_cnt++;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int dbase;
        int n;
        int seen;
        int dmin;
        int dmax;
        int bad_addr;
        int bad_id;
        int last;

        resetn   = 1'b0;
        start    = 1'b0;
        tile_req = 1'b0;
        tile_x   = '0;
        tile_y   = '0;
        for (int i = 0; i < 512; i++) ram[i] = 3'((i * 5 + 1) % 7);
        ram[43] = 3'd2;

        // Reset state
        repeat (3) tick();
        check("rst_begin", 32'(begin_draw), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_addr", 32'(map_addr), 32'd0);
        check("rst_x", 32'(x_out), 32'd0);
        check("rst_y", 32'(y_out), 32'd0);
        check("rst_id", 32'(sprite_id), 32'd0);
        resetn = 1'b1;
        tick();

        // Single tile at (3,2)
        base  = p_cyc.size();
        dbase = done_cnt;
        tile_x = 5'd3; tile_y = 4'd2; tile_req = 1'b1;
        tick();
        tile_req = 1'b0;
        check("single_busy", 32'(busy), 32'd1);
        check("single_addr", 32'(map_addr), 32'd43);
        check("single_early_begin", 32'(begin_draw), 32'd0);
        tick();
        tick();
        check("single_begin", 32'(begin_draw), 32'd1);
        check("single_x", 32'(x_out), 32'd24);
        check("single_y", 32'(y_out), 32'd16);
        check("single_id", 32'(sprite_id), 32'd2);
        tick();
        check("single_begin_low", 32'(begin_draw), 32'd0);
        check("single_x_hold", 32'(x_out), 32'd24);
        n = 1;
        while (done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("single_done_latency", 32'(n), 32'd66);
        check("single_busy_fall", 32'(busy), 32'd0);
        tick();
        check("single_done_pulse", 32'(done), 32'd0);
        check("single_pulses", 32'(p_cyc.size() - base), 32'd1);
        check("single_done_cnt", 32'(done_cnt - dbase), 32'd1);

        // Out-of-range column
        base = p_cyc.size(); dbase = done_cnt;
        tile_x = 5'd20; tile_y = 4'd0; tile_req = 1'b1;
        tick();
        tile_req = 1'b0;
        seen = 0;
        repeat (80) begin
            if (busy !== 1'b0 || begin_draw !== 1'b0 || done !== 1'b0) seen = 1;
            tick();
        end
        check("oor_x_activity", 32'(seen), 32'd0);
        check("oor_x_pulses", 32'(p_cyc.size() - base + done_cnt - dbase), 32'd0);

        // Out-of-range row
        base = p_cyc.size(); dbase = done_cnt;
        tile_x = 5'd0; tile_y = 4'd15; tile_req = 1'b1;
        tick();
        tile_req = 1'b0;
        seen = 0;
        repeat (80) begin
            if (busy !== 1'b0 || begin_draw !== 1'b0 || done !== 1'b0) seen = 1;
            tick();
        end
        check("oor_y_activity", 32'(seen), 32'd0);
        check("oor_y_pulses", 32'(p_cyc.size() - base + done_cnt - dbase), 32'd0);

        // start and tile_req together, then a tile_req during the redraw
        base = p_cyc.size(); dbase = done_cnt;
        tile_x = 5'd3; tile_y = 4'd2; start = 1'b1; tile_req = 1'b1;
        tick();
        start = 1'b0; tile_req = 1'b0;
        check("full_busy", 32'(busy), 32'd1);
        check("full_first_addr", 32'(map_addr), 32'd0);
        n = 0;
        while (done !== 1'b1 && n < 25000) begin
            tick();
            n++;
            tile_x   = 5'd5;
            tile_req = (n == 1000);
        end
        tile_req = 1'b0;
        check("full_duration", 32'(n), 32'd20400);
        check("full_busy_fall", 32'(busy), 32'd0);
        tick();
        check("full_pulses", 32'(p_cyc.size() - base), 32'd300);
        check("full_done_cnt", 32'(done_cnt - dbase), 32'd1);
        dmin = 1000000; dmax = 0; bad_addr = 0; bad_id = 0;
        last = p_cyc.size() - 1;
        for (int i = base; i <= last; i++) begin
            if (p_addr[i] != i - base) bad_addr++;
            if (p_id[i] != int'(ram[p_addr[i]])) bad_id++;
            if (i > base) begin
                if (p_cyc[i] - p_cyc[i-1] < dmin) dmin = p_cyc[i] - p_cyc[i-1];
                if (p_cyc[i] - p_cyc[i-1] > dmax) dmax = p_cyc[i] - p_cyc[i-1];
            end
        end
        check("full_period_min", 32'(dmin), 32'd68);
        check("full_period_max", 32'(dmax), 32'd68);
        check("full_addr_order", 32'(bad_addr), 32'd0);
        check("full_sprite_ids", 32'(bad_id), 32'd0);
        check("full_last_x", 32'(p_x[last]), 32'd152);
        check("full_last_y", 32'(p_y[last]), 32'd112);

        // Reset during tile 57 of a redraw
        start = 1'b1;
        tick();
        start = 1'b0;
        base = p_cyc.size();
        n = 0;
        while (p_cyc.size() - base < 58 && n < 10000) begin
            tick();
            n++;
        end
        check("mid_tile57_addr", 32'(p_addr[p_cyc.size() - 1]), 32'd57);
        resetn = 1'b0;
        tick();
        check("mid_rst_begin", 32'(begin_draw), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_x", 32'(x_out), 32'd0);
        check("mid_rst_y", 32'(y_out), 32'd0);
        check("mid_rst_addr", 32'(map_addr), 32'd0);
        resetn = 1'b1;
        tick();
        check("mid_idle_busy", 32'(busy), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_busy", 32'(busy), 32'd1);
        check("restart_addr", 32'(map_addr), 32'd0);
        tick();
        tick();
        check("restart_begin", 32'(begin_draw), 32'd1);
        check("restart_x", 32'(x_out), 32'd0);
        check("restart_y", 32'(y_out), 32'd0);
        check("restart_id", 32'(sprite_id), 32'(ram[0]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
